// File: rtl/thread_scheduler.sv
// Barrel-processor thread scheduler: per-thread run state, one-in-flight tracking,
// and a round-robin issue slot with valid/ready handshake toward fetch.
module thread_scheduler #(
   parameter  int NUM_THREADS  = 8,
   localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_valid,
   input  logic [BITS_THREADS-1:0] start_tid,
   input  logic                    halt_valid,
   input  logic [BITS_THREADS-1:0] halt_tid,
   input  logic                    stall_set_valid,
   input  logic [BITS_THREADS-1:0] stall_set_tid,
   input  logic                    stall_clr_valid,
   input  logic [BITS_THREADS-1:0] stall_clr_tid,
   input  logic                    retire_valid,
   input  logic [BITS_THREADS-1:0] retire_tid,
   input  logic                    issue_ready,
   output logic                    issue_valid,
   output logic [BITS_THREADS-1:0] issue_tid,
   output logic [NUM_THREADS-1:0]  active_mask,
   output logic                    idle
);

   typedef enum logic [1:0] {T_IDLE, T_RUN, T_STALL, T_HALT} tstate_e;

   tstate_e                 state_q [NUM_THREADS];
   tstate_e                 state_d [NUM_THREADS];
   logic [NUM_THREADS-1:0]  in_flight_q, in_flight_d, elig;
   logic [BITS_THREADS-1:0] rr_q, rr_d, issue_tid_q, issue_tid_d;
   logic                    issue_valid_q, issue_valid_d;
   logic                    load, found;
   logic [BITS_THREADS-1:0] pick, idx;

   // Only the highest-priority event on a tid is considered; if it is illegal
   // for the current state it is dropped, not passed to a lower-priority one.
   always_comb begin
      for (int t = 0; t < NUM_THREADS; t++) begin
         state_d[t] = state_q[t];
         if (halt_valid && halt_tid == BITS_THREADS'(t)) begin
            state_d[t] = T_HALT;
         end else if (start_valid && start_tid == BITS_THREADS'(t)) begin
            if (state_q[t] == T_IDLE || state_q[t] == T_HALT) state_d[t] = T_RUN;
         end else if (stall_set_valid && stall_set_tid == BITS_THREADS'(t)) begin
            if (state_q[t] == T_RUN) state_d[t] = T_STALL;
         end else if (stall_clr_valid && stall_clr_tid == BITS_THREADS'(t)) begin
            if (state_q[t] == T_STALL) state_d[t] = T_RUN;
         end
      end
   end

   always_comb begin
      for (int t = 0; t < NUM_THREADS; t++) begin
         elig[t]        = (state_q[t] == T_RUN) && !in_flight_q[t];
         active_mask[t] = (state_q[t] == T_RUN) || (state_q[t] == T_STALL);
      end
   end

   // Round-robin search starting just after the last issued tid; the final
   // iteration wraps back onto rr itself.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 1; i <= NUM_THREADS; i++) begin
         idx = rr_q + BITS_THREADS'(i);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign load = !issue_valid_q || issue_ready;

   always_comb begin
      in_flight_d   = in_flight_q;
      issue_valid_d = issue_valid_q;
      issue_tid_d   = issue_tid_q;
      rr_d          = rr_q;
      if (retire_valid) in_flight_d[retire_tid] = 1'b0;
      if (load) begin
         issue_valid_d = found;
         if (found) begin
            issue_tid_d       = pick;
            rr_d              = pick;
            in_flight_d[pick] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NUM_THREADS; t++) state_q[t] <= T_IDLE;
         in_flight_q   <= '0;
         rr_q          <= BITS_THREADS'(NUM_THREADS - 1);
         issue_valid_q <= 1'b0;
         issue_tid_q   <= '0;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) state_q[t] <= state_d[t];
         in_flight_q   <= in_flight_d;
         rr_q          <= rr_d;
         issue_valid_q <= issue_valid_d;
         issue_tid_q   <= issue_tid_d;
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_tid   = issue_tid_q;
   assign idle        = ~|active_mask && ~|in_flight_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: single thread, round-robin, stall,
// backpressure, event conflicts and mid-run reset.
module tb_thread_scheduler;
   localparam int NT = 8;
   localparam int BT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_valid, halt_valid, stall_set_valid, stall_clr_valid, retire_valid;
   logic [BT-1:0] start_tid, halt_tid, stall_set_tid, stall_clr_tid, retire_tid;
   logic          issue_ready;
   logic          issue_valid;
   logic [BT-1:0] issue_tid;
   logic [NT-1:0] active_mask;
   logic          idle;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ret_due [NT];
   bit auto_ret = 1'b0;
   int exp_rr;
   int exp_stall [9] = '{0, 1, 3, 4, 5, 6, 7, 0, 1};
   int exp_clr   [9] = '{3, 4, 5, 6, 7, 0, 1, 2, 3};

   thread_scheduler #(.NUM_THREADS(NT)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_tid(start_tid),
      .halt_valid(halt_valid), .halt_tid(halt_tid),
      .stall_set_valid(stall_set_valid), .stall_set_tid(stall_set_tid),
      .stall_clr_valid(stall_clr_valid), .stall_clr_tid(stall_clr_tid),
      .retire_valid(retire_valid), .retire_tid(retire_tid),
      .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_tid(issue_tid),
      .active_mask(active_mask), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; records each new load and schedules its retire 5 edges later.
   task automatic step();
      logic          pv, pr, rv;
      logic [BT-1:0] rt;
      pv = issue_valid; pr = issue_ready; rv = retire_valid; rt = retire_tid;
      @(posedge clk); #1;
      cyc++;
      if (issue_valid && (!pv || pr)) begin
         chk("ret_load_clash", {31'b0, rv && (rt == issue_tid)}, 0);
         ret_due[issue_tid] = cyc + 5;
      end
      if (auto_ret) begin
         retire_valid = 1'b0;
         for (int t = 0; t < NT; t++) begin
            if (ret_due[t] == cyc + 1) begin
               retire_valid = 1'b1;
               retire_tid   = BT'(t);
               ret_due[t]   = -1;
            end
         end
      end
   endtask

   task automatic clear_due();
      for (int t = 0; t < NT; t++) ret_due[t] = -1;
   endtask

   initial begin
      rst = 1'b1;
      start_valid = 0; halt_valid = 0; stall_set_valid = 0; stall_clr_valid = 0; retire_valid = 0;
      start_tid = 0; halt_tid = 0; stall_set_tid = 0; stall_clr_tid = 0; retire_tid = 0;
      issue_ready = 1'b1;
      clear_due();

      // reset state
      step();
      chk("rst_valid", issue_valid, 0);
      chk("rst_tid", issue_tid, 0);
      chk("rst_mask", active_mask, 0);
      chk("rst_idle", idle, 1);
      rst = 1'b0;

      // single thread
      start_valid = 1; start_tid = 3;
      step();
      start_valid = 0;
      chk("t1_mask", active_mask, 8'h08);
      chk("t1_idle", idle, 0);
      chk("t1_no_issue_yet", issue_valid, 0);
      step();
      chk("t1_issue_v", issue_valid, 1);
      chk("t1_issue_tid", issue_tid, 3);
      step();
      chk("t1_no_reissue_a", issue_valid, 0);
      step();
      chk("t1_no_reissue_b", issue_valid, 0);
      retire_valid = 1; retire_tid = 3;
      step();
      retire_valid = 0;
      chk("t1_retire_edge", issue_valid, 0);
      step();
      chk("t1_reissue_v", issue_valid, 1);
      chk("t1_reissue_tid", issue_tid, 3);
      halt_valid = 1; halt_tid = 3; retire_valid = 1; retire_tid = 3;
      step();
      halt_valid = 0; retire_valid = 0;
      chk("t1_end_valid", issue_valid, 0);
      chk("t1_end_mask", active_mask, 0);
      chk("t1_end_idle", idle, 1);

      // round-robin with all threads started one per cycle
      clear_due();
      auto_ret = 1'b1;
      for (int k = 0; k < NT; k++) begin
         start_valid = 1; start_tid = BT'(k);
         step();
         chk("rr_fill_v", issue_valid, (k >= 1) ? 1 : 0);
         if (k >= 1) chk("rr_fill_tid", issue_tid, k - 1);
      end
      start_valid = 0;
      exp_rr = 7;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("rr_v", issue_valid, 1);
         chk("rr_tid", issue_tid, exp_rr);
         exp_rr = (exp_rr + 1) % NT;
      end

      // stall tid 2: skipped in the rotation but still active
      stall_set_valid = 1; stall_set_tid = 2;
      step();
      stall_set_valid = 0;
      chk("st_tid_first", issue_tid, 7);
      for (int i = 0; i < 9; i++) begin
         step();
         chk("st_v", issue_valid, 1);
         chk("st_tid", issue_tid, exp_stall[i]);
      end
      chk("st_mask", active_mask, 8'hFF);
      stall_clr_valid = 1; stall_clr_tid = 2;
      for (int i = 0; i < 9; i++) begin
         step();
         stall_clr_valid = 0;
         chk("clr_tid", issue_tid, exp_clr[i]);
      end
      step();
      chk("pre_bp_tid", issue_tid, 4);
      step();
      chk("pre_bp_tid5", issue_tid, 5);

      // backpressure holds the slot
      issue_ready = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_v", issue_valid, 1);
         chk("bp_tid", issue_tid, 5);
      end
      issue_ready = 1;
      step();
      chk("bp_release_v", issue_valid, 1);
      chk("bp_release_tid", issue_tid, 6);

      // conflict on tid 4: halt wins
      halt_valid = 1; halt_tid = 4;
      start_valid = 1; start_tid = 4;
      stall_set_valid = 1; stall_set_tid = 4;
      step();
      start_valid = 0; stall_set_valid = 0;
      chk("conf_m4", active_mask[4], 0);
      chk("conf_mask", active_mask, 8'hEF);
      for (int t = 0; t < NT; t++) begin
         halt_tid = BT'(t);
         step();
      end
      halt_valid = 0;
      for (int i = 0; i < 10; i++) step();
      chk("drain_idle", idle, 1);
      chk("drain_valid", issue_valid, 0);
      chk("drain_mask", active_mask, 0);

      // mid-run reset with three threads in flight
      auto_ret = 1'b0;
      retire_valid = 0;
      for (int t = 0; t < 3; t++) begin
         start_valid = 1; start_tid = BT'(t);
         step();
      end
      start_valid = 0;
      step();
      chk("mr_pre_v", issue_valid, 1);
      chk("mr_pre_tid", issue_tid, 2);
      rst = 1;
      step();
      rst = 0;
      clear_due();
      chk("mr_valid", issue_valid, 0);
      chk("mr_tid", issue_tid, 0);
      chk("mr_mask", active_mask, 0);
      chk("mr_idle", idle, 1);
      start_valid = 1; start_tid = 0;
      step();
      start_valid = 0;
      chk("mr_start_v", issue_valid, 0);
      step();
      chk("mr_issue_v", issue_valid, 1);
      chk("mr_issue_tid", issue_tid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
